uart_rx_ctrl: RTL
=================

# uart_rx_ctrl

Receive-side controller for the UART path. Watches the line for a start bit, sequences the 10-bit frame receiver through `rx_en`, checks the captured frame (start = 0, stop = 1), and buffers good bytes in a small FIFO with a valid/ready output. It sits between the serial pin and the core-side consumer, and owns all framing and overrun policy for the receiver.

## Interface
- `BAUD_W`, 20: width of the baud divisor (clock cycles per bit).
- `FIFO_DEPTH`, 4: receive FIFO entries, power of two, ≥ 2.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `baud` in BAUD_W: cycles per bit. Sampled only in IDLE.
- `rx_line` in 1: raw serial pin, asynchronous.
- `rx_en` out 1: frame receiver enable. Low clears the receiver's counters.
- `rx_in` out 1: synchronized line, forwarded to the frame receiver.
- `bit_cnt` in 10: receiver's binary count of bits sampled so far in the frame (0..10).
- `frame` in 10: receiver's captured frame. `[0]` is the start bit, `[8:1]` is the data (LSB first), `[9]` is the stop bit.
- `m_data` out 8: FIFO head byte.
- `m_valid` out 1: FIFO not empty.
- `m_ready` in 1: consumer accepts the head byte.
- `frame_err` out 1: sticky; a frame was received with a bad stop bit.
- `overrun` out 1: sticky; a good byte was dropped because the FIFO was full.
- `err_clr` in 1: clears both sticky flags.
- `busy` out 1: state is not IDLE.

## Operation
- The line passes through a 2-flop synchronizer (reset value 1) that drives `rx_in`. All decisions below use the synchronized value.
- **IDLE**
  - `rx_en` = 0.
  - If `baud` < 4: stay in IDLE.
  - Otherwise, on a falling edge (previous synced value 1, current 0): latch `baud` into `baud_q`, load the half counter with `baud_q>>1`, go to START_CHK.
- **START_CHK**
  - Count down to 0.
  - At 0: if `rx_in` = 0, go to RECV. Else the start was a glitch; go to IDLE with no error.
- **RECV**
  - `rx_en` = 1.
  - Wait until `bit_cnt` == 10, then go to CHECK.
- **CHECK** (one cycle, `rx_en` still 1)
  - Good frame (`frame[0]` = 0 and `frame[9]` = 1):
    - FIFO not full: push `frame[8:1]`.
    - FIFO full: drop the byte and set `overrun`.
  - Bad frame (`frame[9]` = 0, including a break): drop the byte, set `frame_err`, go to WAIT_HIGH.
  - Good frame: go to IDLE.
- **WAIT_HIGH**
  - `rx_en` = 0.
  - Stay until `rx_in` = 1, then go to IDLE. This prevents re-triggering on a held-low line.
- **FIFO**
  - Pop when `m_valid && m_ready`.
  - A simultaneous push and pop with the FIFO full is legal. The push succeeds and there is no overrun.
  - `m_data` is the head entry, stable while `m_valid` && !`m_ready`.
- **Sticky flags**
  - `err_clr` clears both flags.
  - If a set event and `err_clr` occur in the same cycle, the set wins.

## Timing
- **Reset values:** state IDLE, `rx_en` 0, `rx_in` 1, `m_valid` 0, `m_data` 0x00, `frame_err` 0, `overrun` 0, `busy` 0, FIFO empty.
- **Reset mid-frame:** aborts immediately. `rx_en` drops the cycle after `rst` is sampled. The partial frame is discarded and no flag is set.
- **Line to IDLE detect:** 2 cycles of synchronizer latency from `rx_line` to the IDLE edge detect.
- **Start check:** the START_CHK decision is made `baud_q>>1` cycles after entering the state.
- **Byte to output:** a CHECK push at cycle t gives `m_valid` = 1 at t+1 if the FIFO was empty.
- **Back-to-back frames:** after a good frame, the next start edge is accepted from the IDLE cycle following CHECK.
- **Register boundaries:** all outputs are registered except `m_data`, which is a FIFO read mux from registered storage.

## Structure
- **Shared package `uart_pkg`:**
  - state enum `rx_ctrl_state_t` {IDLE, START_CHK, RECV, CHECK, WAIT_HIGH};
  - `FRAME_BITS` = 10;
  - `BAUD_MIN` = 4.
- **Sub-module `uart_rx_fifo`:**
  - synchronous FIFO, parameterized on depth and width 8;
  - push/pop/full/empty;
  - reusable on the transmit side.
- **Top level:** instantiates the FIFO. The synchronizer, half counter, FSM and flags stay in the top.

## Test plan
- **Single byte:** `baud` = 16; drive frame 0xA5 (start 0, bits LSB first, stop 1), with a bit-accurate model standing in for the receiver.
  - `m_data` = 0xA5 and `m_valid` = 1 one cycle after CHECK.
  - Both flags stay 0.
- **Glitch:** 4-cycle low pulse with `baud` = 16.
  - START_CHK returns to IDLE.
  - `rx_en` never asserts; no FIFO push; no flags.
- **Framing error:** frame 0x3C with stop bit 0, line held low for 40 more cycles, then high.
  - `frame_err` = 1; no push.
  - Controller stays in WAIT_HIGH until the line rises.
  - A following good 0x55 is received correctly.
- **Overrun:** send 5 bytes 0x01..0x05 with `m_ready` = 0 and `FIFO_DEPTH` = 4.
  - FIFO holds 0x01..0x04 and `overrun` = 1.
  - Then `m_ready` = 1 drains 0x01..0x04 in order.
- **Push/pop on full:** FIFO full; the CHECK cycle coincides with `m_ready` = 1.
  - `overrun` stays 0; the new byte lands at the tail.
- **Reset and clear:**
  - Assert `rst` in mid-RECV: next cycle `rx_en` = 0, state IDLE, FIFO empty.
  - `err_clr` on the same cycle as a new `frame_err` event leaves the flag at 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Used by the receive controller and its FIFO.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    RECV,
    CHECK,
    WAIT_HIGH
  } rx_ctrl_state_t;

  localparam int FRAME_BITS = 10;
  localparam int BAUD_MIN   = 4;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO with registered full/empty flags.
// A push into a full FIFO is accepted when a pop happens the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  always_comb begin
    pop_ok  = pop && !empty_q;
    push_ok = push && (!full_q || pop_ok);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (push_ok) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_d = rd_q + 1'b1;
    end
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      cnt_d = cnt_q - 1'b1;
    end
    full_d  = (cnt_d == FULL_CNT);
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign pop_data = mem_q[rd_q];
  assign full     = full_q;
  assign empty    = empty_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detect, frame sequencing,
// framing/overrun policy and the receive byte FIFO.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int BAUD_W     = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BAUD_W-1:0] baud,
  input  logic              rx_line,
  output logic              rx_en,
  output logic              rx_in,
  input  logic [9:0]        bit_cnt,
  input  logic [9:0]        frame,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              frame_err,
  output logic              overrun,
  input  logic              err_clr,
  output logic              busy
);

  rx_ctrl_state_t state_q, state_d;

  logic [BAUD_W-1:0] half_q, half_d;
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic rx_en_q, rx_en_d;
  logic busy_q, busy_d;
  logic frame_err_q, frame_err_d;
  logic overrun_q, overrun_d;

  logic fall, good, bad;
  logic fe_set, ov_set;
  logic push, pop;
  logic fifo_full, fifo_empty;

  always_comb begin
    sync1_d = rx_line;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    fall    = prev_q && !sync2_q;
    good    = !frame[0] && frame[9];
    bad     = !frame[9];
    pop     = !fifo_empty && m_ready;
    state_d = state_q;
    half_d  = half_q;
    fe_set  = 1'b0;
    ov_set  = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (baud >= BAUD_W'(BAUD_MIN) && fall) begin
          half_d  = baud >> 1;
          state_d = START_CHK;
        end
      end
      START_CHK: begin
        if (half_q == '0) begin
          state_d = sync2_q ? IDLE : RECV;
        end else begin
          half_d = half_q - 1'b1;
        end
      end
      RECV: begin
        if (bit_cnt == 10'(FRAME_BITS)) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (bad) begin
          fe_set  = 1'b1;
          state_d = WAIT_HIGH;
        end else begin
          state_d = IDLE;
          if (good) begin
            // a pop this cycle frees the slot, so no overrun
            if (fifo_full && !pop) begin
              ov_set = 1'b1;
            end else begin
              push = 1'b1;
            end
          end
        end
      end
      WAIT_HIGH: begin
        if (sync2_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rx_en_d     = (state_d == RECV) || (state_d == CHECK);
    busy_d      = (state_d != IDLE);
    frame_err_d = fe_set || (frame_err_q && !err_clr);
    overrun_d   = ov_set || (overrun_q && !err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      half_q      <= '0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      rx_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      half_q      <= half_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      rx_en_q     <= rx_en_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(frame[8:1]),
    .pop      (pop),
    .pop_data (m_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign rx_en     = rx_en_q;
  assign rx_in     = sync2_q;
  assign m_valid   = !fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule
